lsnn_tdm_scheduler: RTL and testbench
=====================================

// Module: lsnn_tdm_scheduler
// PURPOSE
//   Time-multiplexes one shared LSNN neuron datapath (leak, integrate, fire, adaptive threshold)
//   across NUM_NEURONS virtual neurons.
//   Per-neuron state (membrane, threshold, input current) lives in a local state store.
//   On each timestep strobe the block sequences every neuron through the datapath in round-robin
//   order, writes the results back, and publishes a spike vector.
//   It sits between the host/input logic and the single neuron core in the top-level tile.
// PARAMETERS
//   NUM_NEURONS  4  virtual neurons served; power of two, 2..16
//   DW           8  width of membrane, threshold and current words (unsigned)
//   THR_INIT     8'h20  threshold loaded into every neuron at reset
//   REFRAC_TS    2  timesteps a neuron is held after spiking (REFRACTORY_EN only)
// PORTS
//   clk         in   1       single clock, rising edge
//   rst         in   1       synchronous, active-high reset
//   tick        in   1       timestep strobe; starts one full sweep
//   cur_we      in   1       host write of input current
//   cur_addr    in   log2N   neuron index for cur_we
//   cur_data    in   DW      current value
//   dp_valid    out  1       request to the shared datapath
//   dp_ready    in   1       datapath accepts the request
//   dp_mem_in   out  DW      membrane operand
//   dp_thr_in   out  DW      threshold operand
//   dp_cur_in   out  DW      current operand
//   dp_done     in   1       result valid, 1-cycle pulse
//   dp_mem_out  in   DW      updated membrane
//   dp_thr_out  in   DW      updated threshold
//   dp_spike    in   1       neuron fired
//   spikes      out  N       spike vector of the last completed sweep
//   frame_done  out  1       1-cycle pulse when spikes is updated
//   busy        out  1       sweep in progress
//   overrun     out  1       sticky: tick arrived while busy
// BEHAVIOUR
//   Reset: every output 0; all membranes and currents 0; all thresholds THR_INIT; FSM to IDLE.
//     Reset mid-sweep aborts the sweep and emits no frame_done.
//   FSM: IDLE -> FETCH -> ISSUE -> WAIT -> WB -> (FETCH for the next index | DONE) -> IDLE.
//   IDLE: busy=0. A tick moves to FETCH with idx=0.
//   FETCH (1 cycle): latch mem/thr/cur[idx] into operand registers.
//   ISSUE: dp_valid=1 with stable operands until dp_valid&&dp_ready, then go to WAIT.
//   WAIT: hold until dp_done, ignoring dp_* result lines before that.
//   WB (1 cycle): write mem/thr[idx]; spike_acc[idx]=dp_spike; idx++.
//   DONE (1 cycle): spikes<=spike_acc; frame_done=1.
//   Timing: with dp_ready=1 and dp_done one cycle after accept, each neuron takes 4 cycles.
//     frame_done asserts 4*N+1 cycles after the cycle tick is sampled. busy=1 in every non-IDLE state.
//   tick while busy: ignored, overrun<=1 and held until reset. A tick in the DONE cycle also counts as overrun.
//   Host writes:
//     - cur_we is accepted in any state; the current persists across timesteps until rewritten.
//     - cur_we to the same index in the cycle it is FETCHed: FETCH reads the old value;
//       the new value is used next timestep.
//   The block performs no arithmetic on results; the datapath owns width and saturation.
//   Write-back stores dp_*_out unchanged.
//   The index wraps modulo N; the sweep ends after index N-1.
// CONFIGURATION
//   REFRACTORY_EN defined:
//     - Per-neuron counter ref[idx], width clog2(REFRAC_TS+1).
//     - WB with dp_spike=1 loads REFRAC_TS.
//     - In FETCH, a neuron with ref!=0 skips ISSUE/WAIT: it goes straight to WB,
//       mem<=0, threshold unchanged, spike=0, ref--.
//   REFRACTORY_EN undefined: every neuron is always issued; no counters exist.
// STRUCTURE
//   Package lsnn_sched_pkg:
//     - FSM state enum (IDLE, FETCH, ISSUE, WAIT, WB, DONE)
//     - DW / index-width localparams
//     - THR_INIT default
//   Sub-module lsnn_state_ram: N-entry store of {mem, thr, cur}.
//     - Two write ports: host cur, and WB mem/thr.
//     - One read port, registered on FETCH.
//     - Reset-initialised as above.
//   The scheduler top holds the FSM, operand registers, spike accumulator and the flags.
// TESTING
//   1 Reset, then a tick with dp_ready=1, done latency 1, N=4:
//     dp_valid pulses 4x; frame_done at cycle 17 after tick; busy low afterwards.
//   2 cur=8'h10 on n2; datapath model returns mem=cur, spike=1 only for n2:
//     spikes=4'b0100, and mem[2]=8'h10 is written back.
//   3 dp_ready held low 5 cycles on n1: dp_valid and operands stay stable;
//     frame_done slips by exactly 5 cycles.
//   4 Second tick 3 cycles after the first: overrun=1 and stays 1; exactly one frame_done.
//   5 cur_we to n0 in n0's FETCH cycle with 8'h55 (old 8'h11):
//     dp_cur_in=8'h11; the next sweep uses 8'h55.
//   6 rst at mid-sweep (during WAIT of n2): no frame_done; thr reads THR_INIT;
//     with REFRACTORY_EN, a spiking n0 skips the datapath for 2 sweeps
//     (dp_valid count 3 per sweep) and is issued again on the third.

Source files
------------

// File: rtl/lsnn_sched_pkg.sv
// ---------------------------------------------------------------------------
// lsnn_sched_pkg
//   Shared definitions for the LSNN time-multiplexed neuron scheduler:
//   FSM state encoding, default word/index widths, default threshold and
//   refractory length. No ports; imported by the scheduler, its state store
//   and the testbench.
// ---------------------------------------------------------------------------
package lsnn_sched_pkg;

    localparam int          NUM_NEURONS_DEF = 4;
    localparam int          DW_DEF          = 8;
    localparam int          IW_DEF          = $clog2(NUM_NEURONS_DEF);
    localparam logic [7:0]  THR_INIT_DEF    = 8'h20;
    localparam int          REFRAC_TS_DEF   = 2;

    // One neuron visit is FETCH -> ISSUE -> WAIT -> WB; a sweep ends in DONE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/lsnn_tdm_scheduler_if.sv
// ---------------------------------------------------------------------------
// lsnn_tdm_scheduler_if
//   Request/result bundle between the scheduler and the shared neuron
//   datapath.
//   master (scheduler): drives dp_valid, dp_mem_in, dp_thr_in, dp_cur_in;
//                       receives dp_ready, dp_done, dp_mem_out, dp_thr_out,
//                       dp_spike.
//   slave  (datapath) : the mirror image.
//   dp_valid/dp_ready : request handshake, operands stable while pending.
//   dp_done           : 1-cycle pulse qualifying dp_mem_out/dp_thr_out/dp_spike.
// ---------------------------------------------------------------------------
interface lsnn_tdm_scheduler_if #(
    parameter int DW = 8
);
    logic          dp_valid;
    logic          dp_ready;
    logic [DW-1:0] dp_mem_in;
    logic [DW-1:0] dp_thr_in;
    logic [DW-1:0] dp_cur_in;
    logic          dp_done;
    logic [DW-1:0] dp_mem_out;
    logic [DW-1:0] dp_thr_out;
    logic          dp_spike;

    modport master (
        output dp_valid, dp_mem_in, dp_thr_in, dp_cur_in,
        input  dp_ready, dp_done, dp_mem_out, dp_thr_out, dp_spike
    );

    modport slave (
        input  dp_valid, dp_mem_in, dp_thr_in, dp_cur_in,
        output dp_ready, dp_done, dp_mem_out, dp_thr_out, dp_spike
    );
endinterface

// File: rtl/lsnn_state_ram.sv
// ---------------------------------------------------------------------------
// lsnn_state_ram
//   Per-neuron state store of {membrane, threshold, input current}.
//   clk, rst            : clock, synchronous active-high reset
//   cur_we/addr/data    : host write port for the input current
//   wb_we/addr/mem/thr  : write-back port for membrane and threshold
//   rd_en/rd_addr       : read strobe; rd_mem/rd_thr/rd_cur are registered
//                         and hold their value until the next rd_en
//   On reset every membrane and current is 0 and every threshold THR_INIT.
// ---------------------------------------------------------------------------
module lsnn_state_ram
    import lsnn_sched_pkg::*;
#(
    parameter  int            NUM_NEURONS = NUM_NEURONS_DEF,
    parameter  int            DW          = DW_DEF,
    parameter  logic [DW-1:0] THR_INIT    = DW'(THR_INIT_DEF),
    localparam int            IW          = $clog2(NUM_NEURONS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cur_we,
    input  logic [IW-1:0] cur_addr,
    input  logic [DW-1:0] cur_data,
    input  logic          wb_we,
    input  logic [IW-1:0] wb_addr,
    input  logic [DW-1:0] wb_mem,
    input  logic [DW-1:0] wb_thr,
    input  logic          rd_en,
    input  logic [IW-1:0] rd_addr,
    output logic [DW-1:0] rd_mem,
    output logic [DW-1:0] rd_thr,
    output logic [DW-1:0] rd_cur
);

    logic [DW-1:0] mem_q [NUM_NEURONS];
    logic [DW-1:0] thr_q [NUM_NEURONS];
    logic [DW-1:0] cur_q [NUM_NEURONS];

    // NOTE: this store is a small register file whose reset contents are
    // architectural (thresholds start at THR_INIT), so it is reset entry by
    // entry; a block RAM could not be cleared this way.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mem_q[i] <= '0;
                thr_q[i] <= THR_INIT;
                cur_q[i] <= '0;
            end
        end else begin
            // The two write ports touch disjoint fields, so they never collide.
            if (cur_we) cur_q[cur_addr] <= cur_data;
            if (wb_we) begin
                mem_q[wb_addr] <= wb_mem;
                thr_q[wb_addr] <= wb_thr;
            end
        end
    end

    // NOTE: non-blocking assignments make a read in the same cycle as a host
    // write return the old current; the new value appears next timestep.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_mem <= '0;
            rd_thr <= '0;
            rd_cur <= '0;
        end else if (rd_en) begin
            rd_mem <= mem_q[rd_addr];
            rd_thr <= thr_q[rd_addr];
            rd_cur <= cur_q[rd_addr];
        end
    end

endmodule

// File: rtl/lsnn_tdm_scheduler.sv
// ---------------------------------------------------------------------------
// lsnn_tdm_scheduler
//   Sequences NUM_NEURONS virtual LSNN neurons through one shared datapath
//   on every timestep strobe, writes results back and publishes a spike
//   vector.
//   clk, rst        : clock, synchronous active-high reset
//   tick            : timestep strobe, starts one sweep when idle
//   cur_we/addr/data: host write of a neuron's input current
//   dp              : datapath request/result bundle (master side)
//   spikes          : spike vector of the last completed sweep
//   frame_done      : 1-cycle pulse coinciding with a spikes update
//   busy            : sweep in progress
//   overrun         : sticky, a tick arrived while busy
//   Build option REFRACTORY_EN: a neuron that spikes is held for REFRAC_TS
//   sweeps, bypassing the datapath with its membrane cleared.
// ---------------------------------------------------------------------------
module lsnn_tdm_scheduler
    import lsnn_sched_pkg::*;
#(
    parameter  int            NUM_NEURONS = NUM_NEURONS_DEF,
    parameter  int            DW          = DW_DEF,
    parameter  logic [DW-1:0] THR_INIT    = DW'(THR_INIT_DEF),
    parameter  int            REFRAC_TS   = REFRAC_TS_DEF,
    localparam int            IW          = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   cur_we,
    input  logic [IW-1:0]          cur_addr,
    input  logic [DW-1:0]          cur_data,
    lsnn_tdm_scheduler_if.master   dp,
    output logic [NUM_NEURONS-1:0] spikes,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   overrun
);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q;
    logic [DW-1:0]          op_mem, op_thr, op_cur;
    logic [DW-1:0]          res_mem_q, res_thr_q;
    logic                   res_spike_q;
    logic [NUM_NEURONS-1:0] spike_acc_q;
    logic                   last_idx;
    logic                   fetch_skip;   // neuron at idx_q bypasses the datapath
    logic                   skip_q;       // the neuron now in WB was bypassed
    logic                   rd_en, wb_we, dp_valid_c;
    logic [DW-1:0]          wb_mem, wb_thr;

    assign last_idx = (idx_q == IW'(NUM_NEURONS - 1));

`ifdef REFRACTORY_EN
    localparam int RW = (REFRAC_TS > 0) ? $clog2(REFRAC_TS + 1) : 1;

    logic [RW-1:0] ref_q [NUM_NEURONS];

    assign fetch_skip = (ref_q[idx_q] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) ref_q[i] <= '0;
        end else begin
            if (state_q == S_FETCH) skip_q <= fetch_skip;
            if (state_q == S_WB) begin
                if (skip_q)           ref_q[idx_q] <= ref_q[idx_q] - 1'b1;
                else if (res_spike_q) ref_q[idx_q] <= RW'(REFRAC_TS);
            end
        end
    end
`else
    // Without refractory support every neuron is issued; REFRAC_TS has no effect.
    logic unused_refrac;
    assign unused_refrac = (REFRAC_TS != 0);
    assign fetch_skip    = 1'b0;
    assign skip_q        = 1'b0;
`endif

    // A bypassed neuron writes back a cleared membrane and its own threshold.
    assign wb_mem = skip_q ? '0     : res_mem_q;
    assign wb_thr = skip_q ? op_thr : res_thr_q;

    lsnn_state_ram #(
        .NUM_NEURONS (NUM_NEURONS),
        .DW          (DW),
        .THR_INIT    (THR_INIT)
    ) u_state_ram (
        .clk      (clk),
        .rst      (rst),
        .cur_we   (cur_we),
        .cur_addr (cur_addr),
        .cur_data (cur_data),
        .wb_we    (wb_we),
        .wb_addr  (idx_q),
        .wb_mem   (wb_mem),
        .wb_thr   (wb_thr),
        .rd_en    (rd_en),
        .rd_addr  (idx_q),
        .rd_mem   (op_mem),
        .rd_thr   (op_thr),
        .rd_cur   (op_cur)
    );

    // NOTE: every signal written here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b1;
        dp_valid_c = 1'b0;
        rd_en      = 1'b0;
        wb_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (tick) state_d = S_FETCH;
            end
            S_FETCH: begin
                rd_en   = 1'b1;
                state_d = fetch_skip ? S_WB : S_ISSUE;
            end
            S_ISSUE: begin
                dp_valid_c = 1'b1;
                if (dp.dp_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dp.dp_done) state_d = S_WB;
            end
            S_WB: begin
                wb_we   = 1'b1;
                state_d = last_idx ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            res_mem_q   <= '0;
            res_thr_q   <= '0;
            res_spike_q <= 1'b0;
            spike_acc_q <= '0;
            spikes      <= '0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= 1'b0;
            // Includes the DONE cycle: a sweep is only over once back in IDLE.
            if (tick && state_q != S_IDLE) overrun <= 1'b1;
            case (state_q)
                S_IDLE: if (tick) idx_q <= '0;
                S_WAIT: begin
                    // Result lines are don't-care until the done pulse.
                    if (dp.dp_done) begin
                        res_mem_q   <= dp.dp_mem_out;
                        res_thr_q   <= dp.dp_thr_out;
                        res_spike_q <= dp.dp_spike;
                    end
                end
                S_WB: begin
                    spike_acc_q[idx_q] <= res_spike_q & ~skip_q;
                    idx_q              <= idx_q + 1'b1;
                end
                S_DONE: begin
                    spikes     <= spike_acc_q;
                    frame_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dp.dp_valid  = dp_valid_c;
    assign dp.dp_mem_in = op_mem;
    assign dp.dp_thr_in = op_thr;
    assign dp.dp_cur_in = op_cur;

endmodule

// File: tb/tb_lsnn_tdm_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lsnn_tdm_scheduler
//   Directed bench for lsnn_tdm_scheduler (N=4, DW=8). A datapath model
//   answers requests with mem=cur, spike=(cur>=0x10), thr=thr+spike.
//   Expected operands and frames are queued with each stimulus and checked
//   by an independent monitor. Extra refractory sweeps run when
//   REFRACTORY_EN is defined.
// ---------------------------------------------------------------------------
module tb_lsnn_tdm_scheduler;
    import lsnn_sched_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct {
        logic [7:0] mem;
        logic [7:0] thr;
        logic [7:0] cur;
    } op_t;

    typedef struct {
        logic [N-1:0] spk;
        int           lat;
        int           issues;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic         cur_we = 1'b0;
    logic [1:0]   cur_addr = '0;
    logic [7:0]   cur_data = '0;
    logic [N-1:0] spikes;
    logic         frame_done, busy, overrun;

    lsnn_tdm_scheduler_if #(.DW(DW)) dp_if ();

    lsnn_tdm_scheduler #(
        .NUM_NEURONS (N),
        .DW          (DW),
        .THR_INIT    (8'h20),
        .REFRAC_TS   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .cur_we     (cur_we),
        .cur_addr   (cur_addr),
        .cur_data   (cur_data),
        .dp         (dp_if),
        .spikes     (spikes),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial forever #5 clk = ~clk;

    op_t    exp_ops[$];
    frame_t exp_frames[$];
    int     n_checks = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     tick_cyc = 0;
    int     frames_seen = 0;
    int     acc_cnt = 0;
    int     stall_left = 0;
    int     stall_target = 1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- datapath model (drives 2 time units after posedge) ----
    initial begin : dp_model
        int         m_cnt;
        logic       pend;
        logic [7:0] p_mem, p_thr;
        logic       p_spk;
        m_cnt = 0;
        pend  = 1'b0;
        dp_if.dp_ready   = 1'b1;
        dp_if.dp_done    = 1'b0;
        dp_if.dp_mem_out = 8'hEE;
        dp_if.dp_thr_out = 8'hEE;
        dp_if.dp_spike   = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                m_cnt = 0;
                pend  = 1'b0;
                dp_if.dp_ready   = 1'b1;
                dp_if.dp_done    = 1'b0;
                dp_if.dp_mem_out = 8'hEE;
                dp_if.dp_thr_out = 8'hEE;
                dp_if.dp_spike   = 1'b1;
            end else begin
                if (pend) begin
                    dp_if.dp_done    = 1'b1;
                    dp_if.dp_mem_out = p_mem;
                    dp_if.dp_thr_out = p_thr;
                    dp_if.dp_spike   = p_spk;
                    pend = 1'b0;
                end else begin
                    // Garbage on the result lines outside the done pulse.
                    dp_if.dp_done    = 1'b0;
                    dp_if.dp_mem_out = 8'hEE;
                    dp_if.dp_thr_out = 8'hEE;
                    dp_if.dp_spike   = 1'b1;
                end
                dp_if.dp_ready = 1'b1;
                if (dp_if.dp_valid) begin
                    if ((m_cnt % N) == stall_target && stall_left > 0) begin
                        dp_if.dp_ready = 1'b0;
                        stall_left--;
                    end else begin
                        p_spk = (dp_if.dp_cur_in >= 8'h10);
                        p_mem = dp_if.dp_cur_in;
                        p_thr = dp_if.dp_thr_in + {7'd0, p_spk};
                        pend  = 1'b1;
                        m_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- monitor (samples on negedge) ---------------------------
    initial begin : monitor
        frame_t f;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_cnt = 0;
            end else begin
                if (dp_if.dp_valid) begin
                    if (exp_ops.size() == 0) begin
                        check("unexpected_request", 1, 0);
                    end else begin
                        check("op_mem", dp_if.dp_mem_in, exp_ops[0].mem);
                        check("op_thr", dp_if.dp_thr_in, exp_ops[0].thr);
                        check("op_cur", dp_if.dp_cur_in, exp_ops[0].cur);
                        if (dp_if.dp_ready) begin
                            void'(exp_ops.pop_front());
                            acc_cnt++;
                        end
                    end
                end
                if (frame_done) begin
                    frames_seen++;
                    if (exp_frames.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        f = exp_frames.pop_front();
                        check("spikes", spikes, f.spk);
                        check("frame_latency", cyc - tick_cyc, f.lat);
                        check("issue_count", acc_cnt, f.issues);
                    end
                    acc_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers (drive 1 time unit after posedge) -----
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        cur_we   = 1'b1;
        cur_addr = a;
        cur_data = d;
        step();
        cur_we   = 1'b0;
    endtask

    task automatic do_tick();
        tick     = 1'b1;
        tick_cyc = cyc + 1;
        step();
        tick     = 1'b0;
    endtask

    // Byte i of mems/thrs/curs is neuron i; skip bit i means no request.
    task automatic expect_sweep(input logic [31:0] mems, input logic [31:0] thrs,
                                input logic [31:0] curs, input logic [3:0] skip,
                                input logic [3:0] spk, input int lat, input int issues);
        op_t    o;
        frame_t f;
        for (int i = 0; i < N; i++) begin
            if (!skip[i]) begin
                o.mem = mems[8*i +: 8];
                o.thr = thrs[8*i +: 8];
                o.cur = curs[8*i +: 8];
                exp_ops.push_back(o);
            end
        end
        if (lat > 0) begin
            f.spk    = spk;
            f.lat    = lat;
            f.issues = issues;
            exp_frames.push_back(f);
        end
    endtask

    task automatic wait_frame(input int budget);
        int start;
        int n;
        start = frames_seen;
        n = 0;
        while (frames_seen == start && n < budget) begin
            step();
            n++;
        end
        check("frame_timeout", (frames_seen != start), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence --------------------------------------
    initial begin : stimulus
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step();
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_spikes", spikes, 0);
        check("reset_overrun", overrun, 0);
        check("reset_dp_valid", dp_if.dp_valid, 0);
        check("reset_thr_in", dp_if.dp_thr_in, 0);

        // 1: plain sweep, four requests, frame at 4*N+1.
        expect_sweep(32'h0, 32'h20202020, 32'h0, 4'b0000, 4'b0000, 17, 4);
        do_tick();
        wait_frame(60);
        check("busy_after_frame", busy, 0);

        // 2: only n2 has a spiking current; its membrane is written back.
        host_write(2'd2, 8'h10);
        expect_sweep(32'h0, 32'h20202020, 32'h00100000, 4'b0000, 4'b0100, 17, 4);
        do_tick();
        wait_frame(60);

        // 3: 5-cycle stall on n1; n2 now sees mem=0x10, thr=0x21.
        stall_target = 1;
        stall_left   = 5;
        expect_sweep(32'h00100000, 32'h20212020, 32'h00100000, 4'b0000, 4'b0100, 22, 4);
        do_tick();
        wait_frame(60);

        // 4: second tick 3 cycles into the sweep.
        expect_sweep(32'h00100000, 32'h20222020, 32'h00100000, 4'b0000, 4'b0100, 17, 4);
        do_tick();
        step(2);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("overrun_set", overrun, 1);
        check("busy_mid_sweep", busy, 1);
        wait_frame(60);
        step(25);
        check("overrun_held", overrun, 1);

        // 5: host write to n0 during n0's FETCH; old current is used this sweep.
        host_write(2'd0, 8'h11);
        expect_sweep(32'h00100000, 32'h20232020, 32'h00100011, 4'b0000, 4'b0101, 17, 4);
        do_tick();
        host_write(2'd0, 8'h55);
        wait_frame(60);
        expect_sweep(32'h00100011, 32'h20242021, 32'h00100055, 4'b0000, 4'b0101, 17, 4);
        do_tick();
        wait_frame(60);

        // 6: reset while n2 waits for its result; no frame may follow.
        check("overrun_before_reset", overrun, 1);
        expect_sweep(32'h00100055, 32'h20252022, 32'h00100055, 4'b1000, 4'b0000, 0, 0);
        do_tick();
        step(10);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_overrun", overrun, 0);
        check("abort_spikes", spikes, 0);
        check("abort_requests_drained", exp_ops.size(), 0);
        step(25);
        expect_sweep(32'h0, 32'h20202020, 32'h0, 4'b0000, 4'b0000, 17, 4);
        do_tick();
        wait_frame(60);

`ifdef REFRACTORY_EN
        // n0 spikes, then is bypassed for two sweeps and issued on the third.
        host_write(2'd0, 8'h10);
        expect_sweep(32'h0, 32'h20202020, 32'h00000010, 4'b0000, 4'b0001, 17, 4);
        do_tick();
        wait_frame(60);
        for (int s = 0; s < 2; s++) begin
            expect_sweep(32'h0, 32'h20202020, 32'h00000010, 4'b0001, 4'b0000, 15, 3);
            do_tick();
            wait_frame(60);
        end
        expect_sweep(32'h0, 32'h20202021, 32'h00000010, 4'b0000, 4'b0001, 17, 4);
        do_tick();
        wait_frame(60);
`endif

        step(20);
        check("ops_left_over", exp_ops.size(), 0);
        check("frames_left_over", exp_frames.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
